// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list
//   FIFO of unallocated physical register tags. Retirement returns old tags on
//   free_tag_1/free_tag_2; rename pulls new destination tags from the head.
//   Tag 0 means "no tag": it is never stored and never allocated.
//
// Ports
//   clk             in   1        clock, all state updates on posedge
//   reset           in   1        synchronous, active-high; restores the boot mapping
//   alloc_req       in   1        rename wants one tag this cycle
//   alloc_valid     out  1        a free tag is available (free_count != 0)
//   alloc_tag       out  TAG_W    tag at the FIFO head, meaningful when alloc_valid=1
//   free_tag_1      in   TAG_W    tag returned by retire slot 1, 0 = none
//   free_tag_2      in   TAG_W    tag returned by retire slot 2, 0 = none
//   free_count      out  TAG_W+1  number of tags currently held
//   err_overflow    out  1        sticky: a push was dropped because the list was full
//   err_double_free out  1        sticky: a tag was freed while already free
//
// Configuration
//   FREELIST_CHECK_EN  when defined, a per-tag is_free vector rejects and flags
//                      double frees; when undefined err_double_free is tied low
//                      and duplicates are stored as-is.

module phys_reg_free_list #(
    parameter int unsigned NUM_PREGS = 64,
    parameter int unsigned NUM_ARCH  = 32,
    parameter int unsigned TAG_W     = $clog2(NUM_PREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_req,
    output logic             alloc_valid,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic [TAG_W-1:0] free_tag_1,
    input  logic [TAG_W-1:0] free_tag_2,
    output logic [TAG_W:0]   free_count,
    output logic             err_overflow,
    output logic             err_double_free
);

    // Tag 0 is never stored, so one slot of the array always stays unused.
    localparam logic [TAG_W:0]   CAPACITY    = (TAG_W+1)'(NUM_PREGS - 1);
    localparam logic [TAG_W:0]   RESET_COUNT = (TAG_W+1)'(NUM_PREGS - NUM_ARCH);
    localparam logic [TAG_W-1:0] RESET_TAIL  = TAG_W'(NUM_PREGS - NUM_ARCH);

    logic [TAG_W-1:0] mem [NUM_PREGS];
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W:0]   count;

    logic             pop;
    logic [TAG_W:0]   base;
    logic [TAG_W:0]   base2;
    logic             dbl1;
    logic             dbl2;
    logic             push1;
    logic             push2;
    logic             ovf1;
    logic             ovf2;
    logic [TAG_W-1:0] wr_idx2;

`ifdef FREELIST_CHECK_EN
    logic [NUM_PREGS-1:0] is_free;
`endif

    assign alloc_valid = (count != '0);
    assign alloc_tag   = mem[head];
    assign free_count  = count;

    always_comb begin
        pop  = alloc_req && alloc_valid;
        // Occupancy seen by the pushes: the same-cycle pop frees a slot first.
        base = count - (TAG_W+1)'(pop);
        dbl1 = 1'b0;
        dbl2 = 1'b0;
`ifdef FREELIST_CHECK_EN
        // Checked against the registered vector; slot 2 also loses to an
        // identical slot-1 tag in the same cycle.
        dbl1 = (free_tag_1 != '0) && is_free[free_tag_1];
        dbl2 = (free_tag_2 != '0) &&
               (is_free[free_tag_2] || (free_tag_2 == free_tag_1));
`endif
        push1   = (free_tag_1 != '0) && !dbl1 && (base < CAPACITY);
        ovf1    = (free_tag_1 != '0) && !dbl1 && !(base < CAPACITY);
        base2   = base + (TAG_W+1)'(push1);
        push2   = (free_tag_2 != '0) && !dbl2 && (base2 < CAPACITY);
        ovf2    = (free_tag_2 != '0) && !dbl2 && !(base2 < CAPACITY);
        // Slot 2 lands directly behind slot 1 only when slot 1 was accepted.
        wr_idx2 = push1 ? tail + TAG_W'(1) : tail;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_PREGS; i++) begin
                mem[i] <= (i < NUM_PREGS - NUM_ARCH) ? TAG_W'(NUM_ARCH + i) : '0;
            end
            head         <= '0;
            tail         <= RESET_TAIL;
            count        <= RESET_COUNT;
            err_overflow <= 1'b0;
        end else begin
            if (push1) begin
                mem[tail] <= free_tag_1;
            end
            if (push2) begin
                mem[wr_idx2] <= free_tag_2;
            end
            head  <= head + TAG_W'(pop);
            tail  <= tail + TAG_W'(push1) + TAG_W'(push2);
            count <= base + (TAG_W+1)'(push1) + (TAG_W+1)'(push2);
            if (ovf1 || ovf2) begin
                err_overflow <= 1'b1;
            end
        end
    end

`ifdef FREELIST_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_PREGS; i++) begin
                is_free[i] <= (i >= NUM_ARCH);
            end
            err_double_free <= 1'b0;
        end else begin
            if (pop) begin
                is_free[alloc_tag] <= 1'b0;
            end
            if (push1) begin
                is_free[free_tag_1] <= 1'b1;
            end
            if (push2) begin
                is_free[free_tag_2] <= 1'b1;
            end
            if (dbl1 || dbl2) begin
                err_double_free <= 1'b1;
            end
        end
    end
`else
    assign err_double_free = 1'b0;
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Self-checking bench for phys_reg_free_list: a queue model of the list
// contents predicts each pop, the predicted tag goes onto a scoreboard when
// the stimulus is driven and is compared when the DUT presents the tag.

module tb_phys_reg_free_list;

    logic       clk;
    logic       reset;
    logic       alloc_req;
    logic       alloc_valid;
    logic [5:0] alloc_tag;
    logic [5:0] free_tag_1;
    logic [5:0] free_tag_2;
    logic [6:0] free_count;
    logic       err_overflow;
    logic       err_double_free;

`ifdef FREELIST_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    phys_reg_free_list dut (
        .clk            (clk),
        .reset          (reset),
        .alloc_req      (alloc_req),
        .alloc_valid    (alloc_valid),
        .alloc_tag      (alloc_tag),
        .free_tag_1     (free_tag_1),
        .free_tag_2     (free_tag_2),
        .free_count     (free_count),
        .err_overflow   (err_overflow),
        .err_double_free(err_double_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int m_q[$];
    int exp_q[$];
    bit m_ovf;
    bit m_dbl;

    task automatic check_val(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit in_model(input int t);
        foreach (m_q[i]) if (m_q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        for (int t = 32; t < 64; t++) m_q.push_back(t);
        m_ovf = 1'b0;
        m_dbl = 1'b0;
    endtask

    // One clock: drive, check combinational alloc side, update model, clock,
    // then check registered state.
    task automatic step(input bit req, input int t1, input int t2, input bit rst);
        bit exp_pop;
        int base;
        int acc;
        int pushes[$];
        alloc_req  = req;
        free_tag_1 = 6'(t1);
        free_tag_2 = 6'(t2);
        reset      = rst;
        #2;
        if (rst) begin
            model_reset();
        end else begin
            check_val("alloc_valid", int'(alloc_valid), int'(m_q.size() != 0));
            exp_pop = req && (m_q.size() != 0);
            if (exp_pop) exp_q.push_back(m_q[0]);
            if (alloc_valid && req) begin
                if (exp_q.size() == 0) check_val("sb_unexpected_pop", 1, 0);
                else check_val("alloc_tag", int'(alloc_tag), exp_q.pop_front());
            end
            base = m_q.size() - int'(exp_pop);
            acc  = 0;
            if (t1 != 0) begin
                if (CHK && in_model(t1)) m_dbl = 1'b1;
                else if (base + acc < 63) begin pushes.push_back(t1); acc++; end
                else m_ovf = 1'b1;
            end
            if (t2 != 0) begin
                if (CHK && (in_model(t2) || t2 == t1)) m_dbl = 1'b1;
                else if (base + acc < 63) begin pushes.push_back(t2); acc++; end
                else m_ovf = 1'b1;
            end
            if (exp_pop) void'(m_q.pop_front());
            foreach (pushes[i]) m_q.push_back(pushes[i]);
        end
        @(posedge clk);
        #1;
        check_val("free_count", int'(free_count), m_q.size());
        check_val("err_overflow", int'(err_overflow), int'(m_ovf));
        check_val("err_double_free", int'(err_double_free), int'(m_dbl));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        alloc_req  = 1'b0;
        free_tag_1 = '0;
        free_tag_2 = '0;
        reset      = 1'b1;

        // Reset overrides same-cycle requests.
        step(1'b1, 9, 11, 1'b1);
        step(1'b0, 0, 0, 1'b0);
        #2;
        check_val("rst_valid", int'(alloc_valid), 1);
        check_val("rst_tag", int'(alloc_tag), 32);
        check_val("rst_count", int'(free_count), 32);
        check_val("rst_ovf", int'(err_overflow), 0);
        check_val("rst_dbl", int'(err_double_free), 0);
        #2;

        // Drain: 32..63 in order, then empty; a further request is ignored.
        for (int i = 0; i < 32; i++) step(1'b1, 0, 0, 1'b0);
        check_val("drain_valid", int'(alloc_valid), 0);
        check_val("drain_count", int'(free_count), 0);
        step(1'b1, 0, 0, 1'b0);
        check_val("empty_req_count", int'(free_count), 0);

        // From empty: free 5,7 with a request; no bypass that cycle.
        alloc_req = 1'b1; free_tag_1 = 6'd5; free_tag_2 = 6'd7;
        #2;
        check_val("nobypass_valid", int'(alloc_valid), 0);
        step(1'b1, 5, 7, 1'b0);
        check_val("free57_count", int'(free_count), 2);
        check_val("free57_head", int'(alloc_tag), 5);
        step(1'b1, 0, 0, 1'b0);
        check_val("free57_next", int'(alloc_tag), 7);
        step(1'b1, 0, 0, 1'b0);

        // Simultaneous alloc + free from count=32; tag 3 lands behind 63.
        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 3, 0, 1'b0);
        check_val("simul_count", int'(free_count), 32);
        for (int i = 0; i < 32; i++) step(1'b1, 0, 0, 1'b0);
        check_val("tail3_drained", int'(free_count), 0);

        // Slot 2 only goes to [tail].
        step(1'b0, 0, 12, 1'b0);
        check_val("slot2_only_tag", int'(alloc_tag), 12);
        step(1'b1, 0, 0, 1'b0);

        // Double free of an already-free tag, both slots.
        step(1'b0, 0, 0, 1'b1);
        step(1'b0, 40, 40, 1'b0);
        check_val("dbl_count", int'(free_count), CHK ? 32 : 34);
        check_val("dbl_flag", int'(err_double_free), int'(CHK));

        // Fill to capacity, then push once more.
        step(1'b0, 0, 0, 1'b1);
        for (int k = 1; k <= 31; k += 2) step(1'b0, k, (k + 1 <= 31) ? k + 1 : 0, 1'b0);
        check_val("full_count", int'(free_count), 63);
        step(1'b0, 1, 0, 1'b0);
        check_val("full_hold", int'(free_count), 63);
        check_val("full_ovf", int'(err_overflow), CHK ? 0 : 1);

        // Mid-stream reset with wrapped pointers and count=10.
        step(1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 32; i++) step(1'b1, 0, 0, 1'b0);
        for (int k = 1; k <= 40; k += 2) step(1'b0, k, k + 1, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b1, 0, 0, 1'b0);
        check_val("pre_reset_count", int'(free_count), 10);
        step(1'b1, 50, 51, 1'b1);
        #2;
        check_val("mid_rst_valid", int'(alloc_valid), 1);
        check_val("mid_rst_tag", int'(alloc_tag), 32);
        check_val("mid_rst_count", int'(free_count), 32);
        check_val("mid_rst_ovf", int'(err_overflow), 0);
        check_val("mid_rst_dbl", int'(err_double_free), 0);
        for (int i = 0; i < 32; i++) step(1'b1, 0, 0, 1'b0);
        step(1'b0, 9, 8, 1'b0);
        step(1'b1, 0, 0, 1'b0);
        step(1'b1, 0, 0, 1'b0);

        // Random mix of requests and frees.
        step(1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 200; i++) begin
            int a;
            int b;
            a = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 63) : 0;
            b = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 63) : 0;
            step(1'($urandom_range(0, 1)), a, b, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
